l2_miss_handler: RTL

- Control stage directly upstream of the L2 n-way tag memory.
- Accepts one block lookup at a time and drives set and tag into the tag memory, then samples the registered hit and way address it returns.
- On a miss: selects a victim way, reads back the victim tag, writes back the block if dirty, fetches the new block, and writes the new tag into the tag memory.
- Owns the per-block valid/dirty state and the per-set round-robin victim pointers.

---
 rtl/l2_miss_handler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/l2_miss_handler.sv
// l2_miss_handler: lookup/miss control in front of the L2 n-way tag memory.
// Define L2_MISS_STATS_EN to build saturating hit/miss/writeback counters.
module l2_miss_handler #(
   parameter int CACHE_BLOCK_CAPACITY = 128,
   parameter int CACHE_SET_SIZE = 4,
   parameter int BW_TAG = 20,
   localparam int BW_CAP = $clog2(CACHE_BLOCK_CAPACITY),
   localparam int BW_GRP = $clog2(CACHE_SET_SIZE),
   localparam int BW_SET = (BW_CAP - BW_GRP > 1) ? BW_CAP - BW_GRP : 1
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     req_i,
   input  logic                     req_wr_i,
   input  logic [BW_SET-1:0]        req_set_i,
   input  logic [BW_TAG-1:0]        req_tag_i,
   output logic                     ready_o,
   output logic                     done_o,
   output logic                     done_hit_o,
   output logic [BW_CAP-1:0]        done_add_o,
   output logic [BW_SET-1:0]        tm_set_o,
   output logic [BW_TAG-1:0]        tm_tag_o,
   output logic [BW_CAP-1:0]        tm_add_o,
   output logic                     tm_wren_o,
   input  logic                     tm_hit_i,
   input  logic [BW_CAP-1:0]        tm_add_i,
   input  logic [BW_TAG-1:0]        tm_tag_i,
   output logic                     mem_req_o,
   output logic                     mem_wb_o,
   output logic [BW_TAG+BW_SET-1:0] mem_addr_o,
   input  logic                     mem_ack_i,
   output logic [31:0]              stat_hit_o,
   output logic [31:0]              stat_miss_o,
   output logic [31:0]              stat_wb_o
);

   localparam int N_SET = 2 ** (BW_CAP - BW_GRP);
   localparam int N_WAY = CACHE_SET_SIZE;
   localparam int BW_WAY = (BW_GRP > 0) ? BW_GRP : 1;
   localparam int SH = BW_CAP - BW_GRP;

   typedef enum logic [3:0] {
      S_IDLE, S_LOOKUP, S_RESOLVE, S_VICTIM, S_WB,
      S_GAP, S_FETCH, S_FILL, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic              wr_q;
   logic [BW_SET-1:0] set_q;
   logic [BW_TAG-1:0] tag_q;
   logic [BW_TAG-1:0] vtag_q;
   logic [BW_CAP-1:0] vic_q;
   logic              done_hit_q;
   logic [BW_CAP-1:0] done_add_q;
   logic [CACHE_BLOCK_CAPACITY-1:0] valid_q;
   logic [CACHE_BLOCK_CAPACITY-1:0] dirty_q;
   logic [BW_WAY-1:0] rr_q [N_SET];

   logic [BW_SET-1:0] sidx;
   logic [BW_WAY-1:0] vic_way;
   logic              vic_free;

   function automatic logic [BW_CAP-1:0] blk(
      input logic [BW_WAY-1:0] w,
      input logic [BW_SET-1:0] s
   );
      logic [BW_CAP-1:0] a;
      a = BW_CAP'(w) << SH;
      if (N_SET > 1) a = a | BW_CAP'(s);
      return a;
   endfunction

   assign sidx = (N_SET > 1) ? set_q : '0;

   // lowest invalid way wins; round-robin only when the set is full
   always_comb begin
      vic_way = rr_q[sidx];
      vic_free = 1'b0;
      for (int w = N_WAY - 1; w >= 0; w--) begin
         if (!valid_q[blk(BW_WAY'(w), set_q)]) begin
            vic_way = BW_WAY'(w);
            vic_free = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (req_i) state_d = S_LOOKUP;
         S_LOOKUP:  state_d = S_RESOLVE;
         S_RESOLVE: state_d = tm_hit_i ? S_DONE : S_VICTIM;
         S_VICTIM:  state_d = (valid_q[vic_q] && dirty_q[vic_q])
                              ? S_WB : S_FETCH;
         S_WB:      if (mem_ack_i) state_d = S_GAP;
         S_GAP:     state_d = S_FETCH;
         S_FETCH:   if (mem_ack_i) state_d = S_FILL;
         S_FILL:    state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_q <= 1'b0;
         set_q <= '0;
         tag_q <= '0;
         vtag_q <= '0;
         vic_q <= '0;
         done_hit_q <= 1'b0;
         done_add_q <= '0;
         valid_q <= '0;
         dirty_q <= '0;
         for (int s = 0; s < N_SET; s++) rr_q[s] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  wr_q <= req_wr_i;
                  set_q <= req_set_i;
                  tag_q <= req_tag_i;
               end
            end
            S_RESOLVE: begin
               if (tm_hit_i) begin
                  done_hit_q <= 1'b1;
                  done_add_q <= tm_add_i;
                  if (wr_q) dirty_q[tm_add_i] <= 1'b1;
               end else begin
                  vic_q <= blk(vic_way, set_q);
                  if (!vic_free)
                     rr_q[sidx] <= (rr_q[sidx] == BW_WAY'(N_WAY - 1))
                                   ? '0 : rr_q[sidx] + 1'b1;
               end
            end
            S_VICTIM: vtag_q <= tm_tag_i;
            S_FILL: begin
               valid_q[vic_q] <= 1'b1;
               dirty_q[vic_q] <= wr_q;
               done_hit_q <= 1'b0;
               done_add_q <= vic_q;
            end
            default: ;
         endcase
      end
   end

   assign ready_o = (state_q == S_IDLE);
   assign done_o = (state_q == S_DONE);
   assign done_hit_o = done_hit_q;
   assign done_add_o = done_add_q;
   assign tm_set_o = set_q;
   assign tm_tag_o = tag_q;
   assign tm_wren_o = (state_q == S_FILL);
   assign tm_add_o = (state_q == S_VICTIM || state_q == S_FILL)
                     ? vic_q : '0;
   assign mem_req_o = (state_q == S_WB) || (state_q == S_FETCH);
   assign mem_wb_o = (state_q == S_WB);
   assign mem_addr_o = (state_q == S_WB)    ? {vtag_q, set_q} :
                       (state_q == S_FETCH) ? {tag_q, set_q}  : '0;

`ifdef L2_MISS_STATS_EN
   logic [31:0] hit_cnt, miss_cnt, wb_cnt;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hit_cnt <= '0;
         miss_cnt <= '0;
         wb_cnt <= '0;
      end else begin
         if (state_q == S_RESOLVE) begin
            if (tm_hit_i) begin
               if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
               if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
         end
         if (state_q == S_WB && mem_ack_i && wb_cnt != '1)
            wb_cnt <= wb_cnt + 1'b1;
      end
   end

   assign stat_hit_o = hit_cnt;
   assign stat_miss_o = miss_cnt;
   assign stat_wb_o = wb_cnt;
`else
   assign stat_hit_o = '0;
   assign stat_miss_o = '0;
   assign stat_wb_o = '0;
`endif

endmodule
